truth_table_capture: RTL and testbench

TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

---
 rtl/truth_table_capture_pkg.sv | 15 +
 rtl/truth_table_capture_settle_timer.sv | 26 ++
 rtl/truth_table_capture.sv | 105 ++++++++++
 tb/tb_truth_table_capture.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/truth_table_capture_pkg.sv
// Shared types and constants for the truth-table capture block.
package truth_table_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_t;

  localparam int          NUM_VECTORS    = 16;
  localparam logic [15:0] DEFAULT_GOLDEN = 16'h8000;
  localparam int          CNT_W          = 8;

endpackage

// File: rtl/truth_table_capture_settle_timer.sv
// Settle counter: counts cycles a stimulus vector has been held.
module settle_timer
  import truth_table_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all 16 vectors into a 4-input block, captures its response table
// and compares it against a golden table.
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = DEFAULT_GOLDEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  stim,
  input  logic        resp,
  output logic        busy,
  output logic [15:0] table_out,
  output logic        match,
  output logic        result_valid,
  input  logic        result_ready
);

  tt_state_t   r_state;
  logic [3:0]  r_stim;
  logic [15:0] r_table;
  logic        r_busy;
  logic        r_valid;
  logic        r_match;

  logic        w_expired;
  logic        w_timer_clr;
  logic        w_timer_en;
  logic [15:0] w_table_nxt;

  // Counter only runs while a vector is being held; any other state parks it at 0.
  assign w_timer_en  = (r_state == ST_DRIVE);
  assign w_timer_clr = (r_state != ST_DRIVE);

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_timer_clr),
    .enable (w_timer_en),
    .expired(w_expired)
  );

  always_comb begin
    w_table_nxt         = r_table;
    w_table_nxt[r_stim] = resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_stim  <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_DRIVE;
            r_stim  <= '0;
            r_table <= '0;
            r_busy  <= 1'b1;
            r_match <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (w_expired) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_table <= w_table_nxt;
          if (r_stim == 4'(NUM_VECTORS - 1)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            // Compare against the next-table value so the last sample is included.
            r_match <= (w_table_nxt == EXPECTED);
          end else begin
            r_stim  <= r_stim + 4'd1;
            r_state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_stim  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stim         = r_stim;
  assign busy         = r_busy;
  assign table_out    = r_table;
  assign match        = r_match;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomized check of truth_table_capture against a table-lookup model of the block under test.
module tb_truth_table_capture;

  localparam int          S     = 2;
  localparam int          HOLD  = S + 1;
  localparam int          S1    = 1;
  localparam int          HOLD1 = S1 + 1;
  localparam logic [15:0] EXP   = 16'h8000;
  localparam int          LIMIT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, resp, result_ready;
  logic [3:0]  stim;
  logic        busy, match, result_valid;
  logic [15:0] table_out;
  logic [15:0] model_tt;

  logic        rst1, start1, resp1, ready1;
  logic [3:0]  stim1;
  logic        busy1, match1, valid1;
  logic [15:0] table1;
  logic [15:0] model_tt1;

  // Block under test: a pure lookup of its own truth table.
  assign resp  = model_tt[stim];
  assign resp1 = model_tt1[stim1];

  truth_table_capture #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .resp(resp), .busy(busy),
    .table_out(table_out), .match(match), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  truth_table_capture #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .stim(stim1), .resp(resp1), .busy(busy1),
    .table_out(table1), .match(match1), .result_valid(valid1),
    .result_ready(ready1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One full sweep on u_dut, from start through handshake.
  task automatic sweep(input logic [15:0] tt, input bit hold_start, input int low_cycles,
                       input bit start_on_ack);
    int edges, bad_stim, bad_busy, bad;
    logic [15:0] tbl;
    logic        m;
    model_tt = tt;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    chk("busy_after_accept", busy, 1);
    edges = 0; bad_stim = 0; bad_busy = 0;
    while (!result_valid && edges < LIMIT) begin
      if (stim !== 4'(edges / HOLD)) bad_stim++;
      if (busy !== 1'b1) bad_busy++;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk("latency", edges, 16 * HOLD);
    chk("stim_seq", bad_stim, 0);
    chk("busy_sweep", bad_busy, 0);
    chk("busy_done", busy, 0);
    chk("stim_done", stim, 15);
    chk("table", table_out, tt);
    chk("match", match, tt == EXP);
    tbl = table_out; m = match; bad = 0;
    repeat (low_cycles) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b1 || table_out !== tbl || match !== m || stim !== 4'd15) bad++;
    end
    chk("done_stable", bad, 0);
    result_ready = 1'b1;
    if (start_on_ack) start = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0; start = 1'b0;
    chk("valid_fall", result_valid, 0);
    chk("stim_idle", stim, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", busy, 0);
  endtask

  initial begin
    int n, bad, edges;
    logic [15:0] rt;
    rst = 1'b1; start = 1'b1; result_ready = 1'b0; model_tt = 16'h8000;
    rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b0; model_tt1 = 16'h8000;

    // Reset values; start held high during reset must be ignored.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim", stim, 0);
    chk("rst_table", table_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_match", match, 0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ignored", busy, 0);

    sweep(16'h8000, 1'b0, 0, 1'b0);   // 4-input AND
    sweep(16'hFFFE, 1'b0, 10, 1'b0);  // 4-input OR, slow consumer
    sweep(16'hFFFE, 1'b1, 0, 1'b1);   // start held every cycle, start with ack
    sweep(EXP ^ (16'd1 << $urandom_range(0, 14)), 1'b0, 1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rt = 16'($urandom);
      sweep(rt, 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Abort mid-sweep at stim == 7.
    model_tt = 16'h8000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (stim !== 4'd7 && n < 200) begin @(posedge clk); #1; n++; end
    chk("reach_stim7", stim, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_stim", stim, 0);
    chk("abort_table", table_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_match", match, 0);
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort_no_result", bad, 0);
    sweep(16'h8000, 1'b0, 2, 1'b0);

    // SETTLE_CYCLES=1 instance: back-to-back sweeps.
    rst1 = 1'b0;
    model_tt1 = 16'($urandom);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    edges = 0;
    while (!valid1 && edges < LIMIT) begin @(posedge clk); #1; edges++; end
    chk("s1_latency", edges, 16 * HOLD1);
    chk("s1_table", table1, model_tt1);
    chk("s1_match", match1, model_tt1 == EXP);
    ready1 = 1'b1;
    @(posedge clk); #1;
    ready1 = 1'b0;
    chk("s1_valid_fall", valid1, 0);
    model_tt1 = 16'h8000;
    start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    chk("s1_b2b_busy", busy1, 1);
    edges = 0;
    while (!valid1 && edges < LIMIT) begin @(posedge clk); #1; edges++; end
    chk("s1_b2b_latency", edges, 16 * HOLD1);
    chk("s1_b2b_table", table1, 16'h8000);
    chk("s1_b2b_match", match1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
